// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command scheduler: command word layout,
// control codes and scheduler FSM states.
package sprite_cmd_pkg;

  localparam int unsigned CMD_W          = 32;
  localparam int unsigned CMD_COMP_LSB   = 26;
  localparam int unsigned CMD_CHILD_LSB  = 21;
  localparam int unsigned CMD_CTRL_LSB   = 17;
  localparam int unsigned CMD_TYPE_LSB   = 14;
  localparam int unsigned CMD_SEL_BIT    = 13;
  localparam int unsigned CMD_PAYLOAD_W  = 13;

  localparam logic [3:0] CTRL_NOP    = 4'h0;
  localparam logic [3:0] CTRL_WRITE  = 4'h1;
  localparam logic [3:0] CTRL_COMMIT = 4'hF;

  typedef struct packed {
    logic [5:0]  comp;
    logic [4:0]  child;
    logic [3:0]  ctrl;
    logic [2:0]  typ;
    logic        sel;
    logic [12:0] payload;
  } cmd_word_t;

  typedef enum logic [1:0] {
    DRAIN,
    WAIT_VB,
    FLUSH
  } sched_state_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth, no write-to-read bypass.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sprite_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push_ok
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_push_ok = w_do_push;
  assign o_head    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Sprite command scheduler: queues CPU words, drains them onto the command bus,
// owns the double-buffer index and issues commit flushes at vblank entry.
// Optional statistics counters are built when SCHED_STATS_EN is defined.
module sprite_cmd_scheduler
  import sprite_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned V_ACTIVE    = 480,
  parameter logic [3:0]  COMMIT_CODE = CTRL_COMMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic        cpu_ready,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf,
  output logic        swap_pulse,
  output logic        overflow,
  output logic [31:0] stat_out
);

  localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);

  sched_state_t r_state;
  sched_state_t w_state_nx;
  cmd_word_t    w_head;
  cmd_word_t    w_cmd_nx;
  logic [31:0]  w_fifo_head;
  logic [31:0]  r_cmd;
  logic         w_full;
  logic         w_empty;
  logic         w_push_ok;
  logic         w_pop;
  logic         w_swap_nx;
  logic         w_drop;
  logic         w_vblank;
  logic         w_vb_rise;
  logic         r_vb_q;
  logic         r_front;
  logic         r_back;
  logic         r_swap;
  logic         r_ovf;
  logic         w_unused_hcount;

  assign w_unused_hcount = ^hcount;

  sprite_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (cpu_write),
    .i_pop     (w_pop),
    .i_data    (cpu_writedata),
    .o_head    (w_fifo_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok)
  );

  assign w_head    = cmd_word_t'(w_fifo_head);
  assign w_vblank  = (vcount >= LP_V_ACTIVE);
  assign w_vb_rise = w_vblank & ~r_vb_q;
  assign w_drop    = cpu_write & ~w_push_ok;

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_cmd_nx   = '0;
    w_swap_nx  = 1'b0;
    unique case (r_state)
      DRAIN: begin
        // A commit stays at the head until its flush cycle so later words queue behind it.
        if (!w_empty) begin
          if (w_head.ctrl == COMMIT_CODE) begin
            w_state_nx = WAIT_VB;
          end else begin
            w_pop        = 1'b1;
            w_cmd_nx     = w_head;
            w_cmd_nx.sel = r_back;
          end
        end
      end
      WAIT_VB: begin
        if (w_vb_rise) w_state_nx = FLUSH;
      end
      FLUSH: begin
        w_pop            = 1'b1;
        w_cmd_nx         = w_head;
        w_cmd_nx.ctrl    = COMMIT_CODE;
        w_cmd_nx.sel     = r_back;
        w_cmd_nx.payload = '0;
        w_swap_nx        = 1'b1;
        w_state_nx       = DRAIN;
      end
      default: w_state_nx = DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DRAIN;
      r_cmd   <= '0;
      r_swap  <= 1'b0;
      r_vb_q  <= 1'b1;
      r_front <= 1'b0;
      r_back  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cmd   <= w_cmd_nx;
      r_swap  <= w_swap_nx;
      r_vb_q  <= w_vblank;
      if (w_swap_nx) begin
        r_front <= r_back;
        r_back  <= ~r_back;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] r_frames;
  logic [15:0] r_drops;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frames <= '0;
      r_drops  <= '0;
    end else begin
      if (w_swap_nx && r_frames != '1) r_frames <= r_frames + 16'd1;
      if (w_drop && r_drops != '1)     r_drops  <= r_drops + 16'd1;
    end
  end

  assign stat_out = {r_frames, r_drops};
`else
  assign stat_out = '0;
`endif

  assign cpu_ready  = ~w_full;
  assign cmd_out    = r_cmd;
  assign front_buf  = r_front;
  assign swap_pulse = r_swap;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Directed plus randomized bench for sprite_cmd_scheduler against a queue-based
// frame/commit model; stats expectations follow SCHED_STATS_EN.
module tb_sprite_cmd_scheduler;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic        cpu_ready;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        front_buf;
  logic        swap_pulse;
  logic        overflow;
  logic [31:0] stat_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] q[$];
  int          m_phase;
  logic        m_vbq;
  logic        m_front;
  logic        m_back;
  logic        m_ovf;
  int unsigned m_frames;
  int unsigned m_drops;
  logic [31:0] e_cmd;
  logic        e_swap;

  always #5 clk = ~clk;

  sprite_cmd_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .V_ACTIVE    (480),
    .COMMIT_CODE (4'hF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_write     (cpu_write),
    .cpu_writedata (cpu_writedata),
    .cpu_ready     (cpu_ready),
    .hcount        (hcount),
    .vcount        (vcount),
    .cmd_out       (cmd_out),
    .front_buf     (front_buf),
    .swap_pulse    (swap_pulse),
    .overflow      (overflow),
    .stat_out      (stat_out)
  );

  function automatic void model_reset();
    q.delete();
    m_phase  = 0;
    m_vbq    = 1'b1;
    m_front  = 1'b0;
    m_back   = 1'b1;
    m_ovf    = 1'b0;
    m_frames = 0;
    m_drops  = 0;
    e_cmd    = 32'h0;
    e_swap   = 1'b0;
  endfunction

  // Phases: 0 = streaming words, 1 = commit waiting for vblank entry, 2 = flush due.
  function automatic void model_clock();
    logic        vb;
    logic        rise;
    int          nphase;
    logic [31:0] h;
    vb     = (vcount >= 10'd480);
    rise   = vb && !m_vbq;
    nphase = m_phase;
    e_cmd  = 32'h0;
    e_swap = 1'b0;
    h      = (q.size() > 0) ? q[0] : 32'h0;
    if (m_phase == 0) begin
      if (q.size() > 0) begin
        if (h[20:17] == 4'hF) nphase = 1;
        else begin
          e_cmd = (h & ~32'h0000_2000) | (32'(m_back) << 13);
          void'(q.pop_front());
        end
      end
    end else if (m_phase == 1) begin
      if (rise) nphase = 2;
    end else begin
      e_cmd  = (h & 32'hFFE1_C000) | 32'h001E_0000 | (32'(m_back) << 13);
      e_swap = 1'b1;
      void'(q.pop_front());
      m_front = m_back;
      m_back  = ~m_back;
      if (m_frames < 65535) m_frames++;
      nphase = 0;
    end
    if (cpu_write) begin
      if (q.size() < DEPTH) q.push_back(cpu_writedata);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    m_vbq   = vb;
    m_phase = nphase;
  endfunction

  function automatic logic [31:0] exp_stat();
`ifdef SCHED_STATS_EN
    logic [15:0] f;
    logic [15:0] d;
    f = 16'(m_frames);
    d = 16'(m_drops);
    return {f, d};
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cmd_out", cmd_out, e_cmd);
    chk("swap_pulse", {31'h0, swap_pulse}, {31'h0, e_swap});
    chk("front_buf", {31'h0, front_buf}, {31'h0, m_front});
    chk("cpu_ready", {31'h0, cpu_ready}, {31'h0, (q.size() < DEPTH)});
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    chk("stat_out", stat_out, exp_stat());
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic [9:0] vc);
    cpu_write     = w;
    cpu_writedata = d;
    vcount        = vc;
    hcount        = 10'($urandom_range(0, 799));
    @(posedge clk);
    model_clock();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [9:0] vc);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, vc);
  endtask

  initial begin
    logic [31:0] d;
    int          vc;
    logic [15:0] exp_drop_lo;

    reset = 1'b0; cpu_write = 1'b0; cpu_writedata = 32'h0; vcount = 10'd0; hcount = 10'd0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Single word: visible two cycles after the strobe, bit 13 forced to back buffer.
    step(1'b1, 32'h2422_0005, 10'd100);
    chk("t1_latency", cmd_out, 32'h0);
    step(1'b0, 32'h0, 10'd100);
    chk("t1_word", cmd_out, 32'h2422_2005);
    step(1'b0, 32'h0, 10'd100);
    chk("t1_after", cmd_out, 32'h0);

    // A, commit, B: flush only at vblank entry, B lands in the new back buffer.
    step(1'b1, 32'h1C22_0123, 10'd100);
    step(1'b1, 32'h001E_0000, 10'd100);
    step(1'b1, 32'h0822_3456, 10'd100);
    idle(5, 10'd100);
    step(1'b0, 32'h0, 10'd479);
    chk("t2_pre_swap", {31'h0, swap_pulse}, 32'h0);
    step(1'b0, 32'h0, 10'd480);
    chk("t2_rise_nop", cmd_out, 32'h0);
    step(1'b0, 32'h0, 10'd481);
    chk("t2_flush", cmd_out, 32'h001E_2000);
    chk("t2_swap", {31'h0, swap_pulse}, 32'h1);
    chk("t2_front", {31'h0, front_buf}, 32'h1);
    step(1'b0, 32'h0, 10'd482);
    chk("t2_b_word", cmd_out, 32'h0822_1456);
    idle(3, 10'd482);
    idle(3, 10'd100);

    // Fill the FIFO behind a waiting commit, then overflow it by one word.
    step(1'b1, 32'h0C1E_4000, 10'd100);
    idle(3, 10'd100);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 32'h0002_0000 | 32'(i) | ((i % 2 == 0) ? 32'h2000 : 32'h0), 10'd100);
    chk("t3_full", {31'h0, cpu_ready}, 32'h0);
    step(1'b1, 32'h0002_0FFF, 10'd100);
    chk("t3_ovf", {31'h0, overflow}, 32'h1);
`ifdef SCHED_STATS_EN
    exp_drop_lo = 16'd1;
`else
    exp_drop_lo = 16'd0;
`endif
    chk("t3_drops", {16'h0, stat_out[15:0]}, {16'h0, exp_drop_lo});
    step(1'b0, 32'h0, 10'd480);
    step(1'b0, 32'h0, 10'd480);
    chk("t3_flush", cmd_out, 32'h0C1E_4000);
    idle(18, 10'd480);
    idle(3, 10'd100);

    // Back-to-back commits need two separate vblank entries.
    step(1'b1, 32'h041E_0000, 10'd100);
    step(1'b1, 32'h081E_0000, 10'd100);
    idle(3, 10'd100);
    step(1'b0, 32'h0, 10'd480);
    step(1'b0, 32'h0, 10'd480);
    chk("t4_front1", {31'h0, front_buf}, 32'h1);
    idle(3, 10'd480);
    chk("t4_one_swap", cmd_out, 32'h0);
    idle(3, 10'd100);
    step(1'b0, 32'h0, 10'd480);
    step(1'b0, 32'h0, 10'd480);
    chk("t4_front0", {31'h0, front_buf}, 32'h0);
    idle(3, 10'd100);

    // Randomized traffic over a fast raster.
    vc = 0;
    for (int i = 0; i < 600; i++) begin
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[20:17] = 4'hF;
      step(1'($urandom_range(0, 1)), d, 10'(vc));
      vc = (vc + 16) % 525;
    end

    // Drain leftovers, make front_buf 1, then reset while a commit waits.
    for (int k = 0; k < 24 && q.size() != 0; k++) begin
      idle(8, 10'd100);
      idle(3, 10'd480);
    end
    idle(3, 10'd100);
    if (m_front == 1'b0) begin
      step(1'b1, 32'h001E_0000, 10'd100);
      idle(3, 10'd100);
      idle(3, 10'd480);
      idle(2, 10'd100);
    end
    chk("t5_front_pre", {31'h0, front_buf}, 32'h1);
    step(1'b1, 32'h101E_0000, 10'd100);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0002_0100 + 32'(i), 10'd100);
    idle(2, 10'd100);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_cmd", cmd_out, 32'h0);
    chk("t5_rst_ready", {31'h0, cpu_ready}, 32'h1);
    chk("t5_rst_front", {31'h0, front_buf}, 32'h0);
    chk("t5_rst_ovf", {31'h0, overflow}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(5, 10'd100);
    idle(3, 10'd480);
    idle(3, 10'd100);
    chk("t5_quiet", cmd_out, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
